// File: rtl/spmv_csr_engine.sv
// rtl/spmv_csr_engine.sv - CSR sparse-matrix x dense-vector engine
//
// Walks row_ptr, streams non-zeros one per cycle through a two-stage signed
// MAC and writes one result word per row.
// Ports:
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_start, i_num_rows      job start pulse and row count (clamped to 2^ROW_AW)
//   i_sat_en                 1 = saturate results to RES_W, 0 = truncate
//   o_rp_en/o_rp_addr        row_ptr read port, i_rp_data one cycle later
//   o_nz_en/o_nz_addr        non-zero read port, i_nz_val/i_nz_col one cycle later
//   o_x_en/o_x_addr          input-vector read port, i_x_data one cycle later
//   o_y_we/o_y_addr/o_y_data result write port
//   o_busy, o_done, o_err    status; o_state exposes the FSM encoding
module spmv_csr_engine #(
  parameter int DW     = 16,
  parameter int ACC_W  = 40,
  parameter int RES_W  = 32,
  parameter int ROW_AW = 5,
  parameter int COL_AW = 4,
  parameter int NNZ_AW = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_start,
  input  logic [ROW_AW:0]          i_num_rows,
  input  logic                     i_sat_en,
  output logic                     o_rp_en,
  output logic [ROW_AW:0]          o_rp_addr,
  input  logic [NNZ_AW:0]          i_rp_data,
  output logic                     o_nz_en,
  output logic [NNZ_AW-1:0]        o_nz_addr,
  input  logic signed [DW-1:0]     i_nz_val,
  input  logic [COL_AW-1:0]        i_nz_col,
  output logic                     o_x_en,
  output logic [COL_AW-1:0]        o_x_addr,
  input  logic signed [DW-1:0]     i_x_data,
  output logic                     o_y_we,
  output logic [ROW_AW-1:0]        o_y_addr,
  output logic [RES_W-1:0]         o_y_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic [2:0]               o_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RP_ADDR = 3'd1,
    RP_CAP  = 3'd2,
    MAC     = 3'd3,
    DRAIN   = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [ROW_AW:0] ONE_R    = (ROW_AW+1)'(1);
  localparam logic [NNZ_AW:0] ONE_K    = (NNZ_AW+1)'(1);
  localparam logic [ROW_AW:0] MAX_ROWS = {1'b1, {ROW_AW{1'b0}}};
  localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN = {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

  state_t state, state_nx;

  logic [ROW_AW:0]          r, n_rows, n_req;
  logic [NNZ_AW:0]          k, start_ptr, end_ptr;
  logic                     first, sat, err;
  logic signed [ACC_W-1:0]  acc;
  logic                     v1, v2;
  logic signed [DW-1:0]     val_q;
  logic signed [2*DW-1:0]   prod;
  logic [RES_W-1:0]         sat_val;

  assign n_req = (i_num_rows > MAX_ROWS) ? MAX_ROWS : i_num_rows;
  assign prod  = (2*DW)'(val_q) * (2*DW)'(i_x_data);

  always_comb begin
    if (acc > RES_MAX)      sat_val = RES_MAX[RES_W-1:0];
    else if (acc < RES_MIN) sat_val = RES_MIN[RES_W-1:0];
    else                    sat_val = acc[RES_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    o_rp_en   = 1'b0;
    o_rp_addr = '0;
    o_nz_en   = 1'b0;
    o_nz_addr = '0;
    o_y_we    = 1'b0;
    o_y_addr  = '0;
    o_y_data  = '0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nx = (n_req == '0) ? DONE : RP_ADDR;
      end
      RP_ADDR: begin
        o_rp_en   = 1'b1;
        o_rp_addr = first ? '0 : r + ONE_R;
        state_nx  = RP_CAP;
      end
      RP_CAP: begin
        // A decreasing pointer is handled as an empty row, so it goes to WRITE too.
        if (first)                       state_nx = RP_ADDR;
        else if (i_rp_data > start_ptr)  state_nx = MAC;
        else                             state_nx = WRITE;
      end
      MAC: begin
        o_nz_en   = 1'b1;
        o_nz_addr = k[NNZ_AW-1:0];
        if (k == end_ptr - ONE_K) state_nx = DRAIN;
      end
      DRAIN: begin
        // First DRAIN cycle still has the last issue in stage 1; leave once it moved on.
        if (!v1) state_nx = WRITE;
      end
      WRITE: begin
        o_y_we   = 1'b1;
        o_y_addr = r[ROW_AW-1:0];
        o_y_data = sat ? sat_val : acc[RES_W-1:0];
        state_nx = (r == n_rows - ONE_R) ? DONE : RP_ADDR;
      end
      DONE: begin
        o_done   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r         <= '0;
      n_rows    <= '0;
      k         <= '0;
      start_ptr <= '0;
      end_ptr   <= '0;
      first     <= 1'b0;
      sat       <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      val_q     <= '0;
    end else begin
      v1 <= (state == MAC);
      v2 <= v1;
      if (v1) val_q <= i_nz_val;
      if (v2) acc <= acc + ACC_W'(prod);
      case (state)
        IDLE: begin
          if (i_start) begin
            n_rows <= n_req;
            sat    <= i_sat_en;
            err    <= 1'b0;
            r      <= '0;
            first  <= 1'b1;
          end
        end
        RP_CAP: begin
          if (first) begin
            start_ptr <= i_rp_data;
            first     <= 1'b0;
          end else begin
            acc <= '0;
            k   <= start_ptr;
            if (i_rp_data < start_ptr) begin
              err     <= 1'b1;
              end_ptr <= start_ptr;
            end else begin
              end_ptr <= i_rp_data;
            end
          end
        end
        MAC:   k <= k + ONE_K;
        WRITE: begin
          start_ptr <= end_ptr;
          if (r != n_rows - ONE_R) r <= r + ONE_R;
        end
        default: ;
      endcase
    end
  end

  assign o_x_en   = v1;
  assign o_x_addr = v1 ? i_nz_col : '0;
  assign o_busy   = (state != IDLE);
  assign o_err    = err;
  assign o_state  = state;

endmodule
